// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the RX FIFO entry layout and the interrupt trigger-level encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_lvl_e;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  // 4 chars x 10 bits x 16 oversample x divisor 6
  localparam int unsigned TIMEOUT_CYC_DEF = 3840;

  // The top setting tracks the FIFO size so deeper FIFOs still leave two slots of slack.
  function automatic int unsigned trig_level(input trig_lvl_e sel, input int unsigned depth);
    int unsigned lvl;
    case (sel)
      TRIG_1:  lvl = 1;
      TRIG_4:  lvl = 4;
      TRIG_8:  lvl = 8;
      default: lvl = depth - 2;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_pulse_sync.sv
// Brings a slow level strobe into the local clock domain and emits one
// single-cycle pulse on each rising edge of that strobe.
module uart_pulse_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the host registers: first-word-fall-through
// storage of {frame_err, parity_err, data} plus 16550-style line status and interrupts.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_wr_en_i,
  input  logic                     parity_error_i,
  input  logic                     frame_error_i,
  input  logic                     rd_en_i,
  input  logic                     lsr_rd_i,
  input  logic                     fifo_clr_i,
  input  logic [1:0]               trig_lvl_i,
  output logic [7:0]               rd_data_o,
  output logic                     rd_parity_err_o,
  output logic                     rd_frame_err_o,
  output logic                     data_ready_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overrun_o,
  output logic                     err_in_fifo_o,
  output logic                     trig_irq_o,
  output logic                     timeout_irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic            push;
  logic            empty, full;
  logic            do_pop, do_push, mem_we;
  logic            new_err, head_err;
  rx_entry_t       wr_entry, head;
  rx_entry_t       mem_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            overrun_q, overrun_d;
  logic            trig_q, trig_d;
  logic            tout_q, tout_d;

  uart_pulse_sync u_wr_sync (
    .clk_i   (sys_clk),
    .rst_ni  (reset),
    .level_i (rx_wr_en_i),
    .pulse_o (push)
  );

  assign wr_entry = {frame_error_i, parity_error_i, rx_data_i};
  assign head     = mem_q[rd_ptr_q];
  assign new_err  = wr_entry.frame_err | wr_entry.parity_err;
  assign head_err = head.frame_err | head.parity_err;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // Pop is applied before push, so a full FIFO popped in the same cycle accepts the character.
  assign do_pop  = rd_en_i & ~empty;
  assign do_push = push & (~full | do_pop);
  assign mem_we  = do_push & ~fifo_clr_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
    err_cnt_d = err_cnt_q + CW'(do_push & new_err) - CW'(do_pop & head_err);
    overrun_d = overrun_q;
    tmr_d     = tmr_q;
    tout_d    = tout_q;
    trig_d    = (count_q >= CW'(trig_level(trig_lvl_e'(trig_lvl_i), DEPTH)));

    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (push && full && !do_pop && !fifo_clr_i) overrun_d = 1'b1;
    else if (lsr_rd_i)                           overrun_d = 1'b0;

    // Timer runs only while characters sit untouched in the FIFO; it saturates at the limit.
    if (push || do_pop || fifo_clr_i || empty) begin
      tmr_d  = '0;
      tout_d = 1'b0;
    end else begin
      if (tmr_q != TW'(TIMEOUT_CYC)) tmr_d = tmr_q + 1'b1;
      tout_d = (tmr_d == TW'(TIMEOUT_CYC));
    end

    if (fifo_clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      tmr_q     <= '0;
      overrun_q <= 1'b0;
      trig_q    <= 1'b0;
      tout_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      tmr_q     <= tmr_d;
      overrun_q <= overrun_d;
      trig_q    <= trig_d;
      tout_q    <= tout_d;
      if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_data_o       = head.data;
  assign rd_parity_err_o = head.parity_err;
  assign rd_frame_err_o  = head.frame_err;
  assign data_ready_o    = ~empty;
  assign count_o         = count_q;
  assign overrun_o       = overrun_q;
  assign err_in_fifo_o   = (err_cnt_q != '0);
  assign trig_irq_o      = trig_q;
  assign timeout_irq_o   = tout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: characters are modelled in a queue of
// expected entries and compared when they reach the head of the FIFO.
module tb_uart_rx_fifo;

  localparam int DEPTH       = 16;
  localparam int TIMEOUT_CYC = 3840;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data_i;
  logic       rx_wr_en_i, parity_error_i, frame_error_i;
  logic       rd_en_i, lsr_rd_i, fifo_clr_i;
  logic [1:0] trig_lvl_i;
  logic [7:0] rd_data_o;
  logic       rd_parity_err_o, rd_frame_err_o, data_ready_o;
  logic [4:0] count_o;
  logic       overrun_o, err_in_fifo_o, trig_irq_o, timeout_irq_o;

  logic [9:0] exp_q[$];
  logic       exp_ovr;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .rx_data_i       (rx_data_i),
    .rx_wr_en_i      (rx_wr_en_i),
    .parity_error_i  (parity_error_i),
    .frame_error_i   (frame_error_i),
    .rd_en_i         (rd_en_i),
    .lsr_rd_i        (lsr_rd_i),
    .fifo_clr_i      (fifo_clr_i),
    .trig_lvl_i      (trig_lvl_i),
    .rd_data_o       (rd_data_o),
    .rd_parity_err_o (rd_parity_err_o),
    .rd_frame_err_o  (rd_frame_err_o),
    .data_ready_o    (data_ready_o),
    .count_o         (count_o),
    .overrun_o       (overrun_o),
    .err_in_fifo_o   (err_in_fifo_o),
    .trig_irq_o      (trig_irq_o),
    .timeout_irq_o   (timeout_irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic any_err();
    foreach (exp_q[i]) if (exp_q[i][9:8] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lvl(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic check_head(input string tag);
    check({tag, "_rdy"}, data_ready_o, exp_q.size() > 0);
    if (exp_q.size() > 0)
      check({tag, "_entry"}, {rd_frame_err_o, rd_parity_err_o, rd_data_o}, exp_q[0]);
  endtask

  // mode: 0 plain, 1 pop on the push edge, 2 lsr read on the push edge, 3 clear on the push edge
  task automatic send_char(input logic [7:0] d, input logic pe, input logic fe, input int mode);
    int   old;
    logic set;
    old = exp_q.size();
    set = 1'b0;
    rx_data_i = d; parity_error_i = pe; frame_error_i = fe;
    rx_wr_en_i = 1'b1;
    tick();
    tick();
    check("cnt_before_push", count_o, old);
    if (mode == 1) rd_en_i = 1'b1;
    if (mode == 2) lsr_rd_i = 1'b1;
    if (mode == 3) fifo_clr_i = 1'b1;
    if (mode == 3) exp_q.delete();
    else begin
      if (mode == 1 && exp_q.size() > 0) begin
        check("head_at_pop", {rd_frame_err_o, rd_parity_err_o, rd_data_o}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() < DEPTH) exp_q.push_back({fe, pe, d});
      else begin
        exp_ovr = 1'b1;
        set     = 1'b1;
      end
      if (mode == 2 && !set) exp_ovr = 1'b0;
    end
    tick();
    rd_en_i = 1'b0; lsr_rd_i = 1'b0; fifo_clr_i = 1'b0; rx_wr_en_i = 1'b0;
    check("cnt_after_push", count_o, exp_q.size());
    check("overrun", overrun_o, exp_ovr);
    check("err_in_fifo", err_in_fifo_o, any_err());
    check("timeout_on_push", timeout_irq_o, 1'b0);
    check("trig_lag", trig_irq_o, old >= lvl(trig_lvl_i));
    check_head("head_after_push");
    tick();
    check("trig_new", trig_irq_o, exp_q.size() >= lvl(trig_lvl_i));
    tick();
  endtask

  task automatic pop_check();
    int old;
    old = exp_q.size();
    check_head("pop_head");
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    void'(exp_q.pop_front());
    check("cnt_after_pop", count_o, exp_q.size());
    check("err_after_pop", err_in_fifo_o, any_err());
    check("timeout_after_pop", timeout_irq_o, 1'b0);
    check("trig_lag_pop", trig_irq_o, old >= lvl(trig_lvl_i));
    tick();
    check("trig_new_pop", trig_irq_o, exp_q.size() >= lvl(trig_lvl_i));
  endtask

  task automatic lsr_read();
    lsr_rd_i = 1'b1;
    tick();
    lsr_rd_i = 1'b0;
    exp_ovr = 1'b0;
    check("overrun_cleared", overrun_o, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    rx_data_i = '0; rx_wr_en_i = 0; parity_error_i = 0; frame_error_i = 0;
    rd_en_i = 0; lsr_rd_i = 0; fifo_clr_i = 0; trig_lvl_i = 2'b00;
    exp_ovr = 1'b0;
    repeat (3) tick();
    check("rst_rdy", data_ready_o, 1'b0);
    check("rst_cnt", count_o, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_flags", {rd_parity_err_o, rd_frame_err_o}, 0);
    check("rst_status", {overrun_o, err_in_fifo_o, trig_irq_o, timeout_irq_o}, 0);
    reset = 1'b1;
    tick();

    // single character, then a pop on an empty FIFO is ignored
    send_char(8'hA5, 1'b0, 1'b0, 0);
    pop_check();
    check("empty_after_pop", data_ready_o, 1'b0);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("pop_empty_ignored", count_o, 0);

    // fill past full, clear overrun, push+pop when full, overrun wins over lsr read
    for (int i = 0; i <= DEPTH; i++) send_char(8'(i), 1'b0, 1'b0, 0);
    check("full_cnt", count_o, DEPTH);
    lsr_read();
    send_char(8'h55, 1'b0, 1'b0, 1);
    send_char(8'h66, 1'b0, 1'b0, 2);
    while (exp_q.size() > 0) pop_check();
    lsr_read();

    // error tracking
    send_char(8'h11, 1'b0, 1'b0, 0);
    send_char(8'hAA, 1'b1, 1'b0, 0);
    send_char(8'h22, 1'b0, 1'b0, 0);
    send_char(8'hBB, 1'b0, 1'b1, 0);
    send_char(8'h33, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) pop_check();

    // trigger levels 4 and DEPTH-2
    trig_lvl_i = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) send_char(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) pop_check();
    trig_lvl_i = 2'b11;
    tick();
    for (int i = 0; i < DEPTH - 1; i++) send_char(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) pop_check();
    trig_lvl_i = 2'b00;
    tick();

    // character timeout: push lands two edges before send_char returns
    send_char(8'h77, 1'b0, 1'b0, 0);
    repeat (TIMEOUT_CYC - 3) tick();
    check("timeout_early", timeout_irq_o, 1'b0);
    tick();
    check("timeout_fire", timeout_irq_o, 1'b1);
    pop_check();

    // clear concurrent with push leaves overrun alone
    for (int i = 0; i < DEPTH; i++) send_char(8'h80 + 8'(i), 1'b0, 1'b0, 0);
    send_char(8'hFF, 1'b0, 1'b0, 0);
    send_char(8'hEE, 1'b1, 1'b0, 3);
    check("clr_cnt", count_o, 0);
    check("clr_overrun", overrun_o, 1'b1);
    lsr_read();

    // asynchronous reset mid-operation
    send_char(8'h3C, 1'b1, 1'b0, 0);
    send_char(8'hC3, 1'b0, 1'b0, 0);
    @(posedge sys_clk);
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check("async_rst_cnt", count_o, 0);
    check("async_rst_rdy", data_ready_o, 1'b0);
    check("async_rst_err", err_in_fifo_o, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    send_char(8'h5A, 1'b0, 1'b1, 0);
    pop_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
